uart_rx_byte: RTL

// Asynchronous serial receiver, 8N1, LSB first, 16x oversampled. Sits directly upstream of the

---
 rtl/uart_rx_byte.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver, LSB first, 16x oversampled, mid-bit sampling.
// Holds one byte at a time. oValid marks a good byte. oFrameErr marks a low stop bit.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on the synchronised line
// START | counting 8 ticks to the middle of the start bit to confirm it
// DATA  | sampling 8 data bits, one every 16 ticks, LSB first
// STOP  | waiting 16 ticks to the middle of the stop bit, then report
module uart_rx_byte #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRx,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFrameErr,
  output logic       oBusy
);

  localparam int OS    = 16;
  localparam int DIV   = CLK_HZ / (BAUD * OS);
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             rx_m_q, rx_s_q, rx_p_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             tick;

  // Two-flop synchroniser for the asynchronous line, plus a delayed copy for edge detection.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= iRx;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign tick = (div_q == DIV_W'(DIV - 1));

  // Oversample tick generation, next-state logic and frame reporting.
  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Only a genuine high-to-low transition starts a frame, so a held-low line never retriggers.
        if (rx_p_q && !rx_s_q) begin
          state_d    = START;
          div_d      = '0;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d[bit_cnt_q] = rx_s_q;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            // Returning to IDLE mid stop bit lets a following start edge be caught with no idle gap.
            state_d = IDLE;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign oData     = data_q;
  assign oValid    = valid_q;
  assign oFrameErr = ferr_q;
  assign oBusy     = (state_q != IDLE);

endmodule
